prt_tx_drain: RTL and testbench

PRT_TX_DRAIN -- requirements
Module: prt_tx_drain

---
 rtl/prt_tx_drain.sv | 221 ++++++++++++++++++++++
 tb/tb_prt_tx_drain.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prt_tx_drain.sv
// Retires queued PRT slots: streams each frame to the MAC (or skips it on drop),
// then invalidates the slot and holds it for the duration of the PRT clear.
module prt_tx_drain #(
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_SLOTS     = 10,
  parameter int MEM_DEPTH     = 1518,
  parameter int QUEUE_DEPTH   = 4,
  parameter int IFG_CYCLES    = 12,
  parameter int START_TIMEOUT = 16,
  localparam int SLOT_W       = $clog2(NUM_SLOTS)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [SLOT_W-1:0]     cmd_slot,
  input  logic                  cmd_drop,
  output logic                  EN_start_reading_prt_entry,
  input  logic                  RDY_start_reading_prt_entry,
  output logic [SLOT_W-1:0]     start_reading_prt_entry_slot,
  output logic                  EN_read_prt_entry,
  input  logic                  RDY_read_prt_entry,
  input  logic [DATA_WIDTH:0]   read_prt_entry,
  output logic                  EN_invalidate_prt_entry,
  input  logic                  RDY_invalidate_prt_entry,
  output logic [SLOT_W-1:0]     invalidate_prt_entry_slot,
  input  logic                  tx_enable,
  output logic                  tx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_last,
  output logic [15:0]           frames_sent,
  output logic [15:0]           frames_dropped,
  output logic                  err_flag,
  output logic                  busy
);

  localparam int PTR_W   = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int QCNT_W  = $clog2(QUEUE_DEPTH + 1);
  localparam int IFG_W   = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;
  localparam int CNT_MAX = (MEM_DEPTH > START_TIMEOUT) ? MEM_DEPTH : START_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_RD_REQ, S_STREAM, S_INV_REQ, S_INV_HOLD} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IFG_W-1:0]        ifg_q, ifg_d;
  logic [DATA_WIDTH-1:0]   hold_q, hold_d;
  logic                    hold_full_q, hold_full_d;
  logic                    tx_valid_q, tx_valid_d, tx_last_q, tx_last_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic [15:0]             sent_q, dropped_q;
  logic                    err_q;
  logic                    en_start_q, en_read_q, en_inv_q;
  logic [SLOT_W-1:0]       start_slot_q, inv_slot_q;
  logic                    sent_inc, drop_inc, err_set, ifg_load, pop;

  // Command FIFO: {drop, slot}; head stays put until INV_HOLD retires it.
  logic [SLOT_W:0]         q_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [QCNT_W-1:0]       q_cnt_q;
  logic                    q_full, q_empty, push, head_drop, rd_take;
  logic [SLOT_W-1:0]       head_slot;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign q_full    = (q_cnt_q == QCNT_W'(QUEUE_DEPTH));
  assign q_empty   = (q_cnt_q == '0);
  assign push      = cmd_valid && !q_full;
  assign head_drop = q_mem[rd_ptr_q][SLOT_W];
  assign head_slot = q_mem[rd_ptr_q][SLOT_W-1:0];
  assign rd_take   = RDY_read_prt_entry && !read_prt_entry[DATA_WIDTH];

  // NOTE: storage arrays carry no reset; the empty count alone makes stale entries unreachable.
  always_ff @(posedge CLK) begin
    if (push) q_mem[wr_ptr_q] <= {cmd_drop, cmd_slot};
  end

  // NOTE: every default is assigned first so no path through this block can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tx_valid_d  = 1'b0;
    tx_last_d   = 1'b0;
    tx_data_d   = '0;
    sent_inc    = 1'b0;
    drop_inc    = 1'b0;
    err_set     = 1'b0;
    ifg_load    = 1'b0;
    pop         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!q_empty) begin
          if (head_drop) state_d = S_INV_REQ;
          else if (tx_enable && ifg_q == '0) state_d = S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        if (RDY_start_reading_prt_entry) begin
          state_d     = S_STREAM;
          cnt_d       = '0;
          hold_full_d = 1'b0;
        end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
          state_d  = S_INV_REQ;
          cnt_d    = '0;
          err_set  = 1'b1;
          drop_inc = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STREAM: begin
        if (rd_take && cnt_q != CNT_W'(MEM_DEPTH)) begin
          hold_d      = read_prt_entry[DATA_WIDTH-1:0];
          hold_full_d = 1'b1;
          cnt_d       = cnt_q + 1'b1;
          tx_valid_d  = hold_full_q;
          tx_data_d   = hold_full_q ? hold_q : '0;
        end else begin
          // End of frame; a byte still arriving after MEM_DEPTH loads marks it overlong.
          state_d     = S_INV_REQ;
          cnt_d       = '0;
          hold_full_d = 1'b0;
          if (hold_full_q) begin
            tx_valid_d = 1'b1;
            tx_last_d  = 1'b1;
            tx_data_d  = hold_q;
            sent_inc   = 1'b1;
            ifg_load   = 1'b1;
            err_set    = rd_take;
          end else begin
            drop_inc = 1'b1;
          end
        end
      end
      S_INV_REQ: begin
        cnt_d = '0;
        if (RDY_invalidate_prt_entry) state_d = S_INV_HOLD;
      end
      S_INV_HOLD: begin
        if (cnt_q == CNT_W'(MEM_DEPTH)) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          pop      = 1'b1;
          drop_inc = head_drop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ifg_d = ifg_load ? IFG_W'(IFG_CYCLES) : ((ifg_q != '0) ? ifg_q - 1'b1 : '0);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      ifg_q        <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_last_q    <= 1'b0;
      tx_data_q    <= '0;
      sent_q       <= '0;
      dropped_q    <= '0;
      err_q        <= 1'b0;
      en_start_q   <= 1'b0;
      en_read_q    <= 1'b0;
      en_inv_q     <= 1'b0;
      start_slot_q <= '0;
      inv_slot_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      q_cnt_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ifg_q        <= ifg_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      tx_valid_q   <= tx_valid_d;
      tx_last_q    <= tx_last_d;
      tx_data_q    <= tx_data_d;
      if (sent_inc) sent_q <= sent_q + 16'd1;
      if (drop_inc) dropped_q <= dropped_q + 16'd1;
      err_q        <= err_q | err_set;
      // Handshake outputs decode the next state, so they are registered and mutually exclusive.
      en_start_q   <= (state_d == S_RD_REQ);
      en_read_q    <= (state_d == S_STREAM);
      en_inv_q     <= (state_d == S_INV_REQ);
      start_slot_q <= (state_d == S_RD_REQ) ? head_slot : '0;
      inv_slot_q   <= (state_d == S_INV_REQ || state_d == S_INV_HOLD) ? head_slot : '0;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      q_cnt_q      <= q_cnt_q + QCNT_W'(push) - QCNT_W'(pop);
    end
  end

  assign cmd_ready                    = !q_full;
  assign busy                         = (state_q != S_IDLE) || !q_empty;
  assign EN_start_reading_prt_entry   = en_start_q;
  assign start_reading_prt_entry_slot = start_slot_q;
  assign EN_read_prt_entry            = en_read_q;
  assign EN_invalidate_prt_entry      = en_inv_q;
  assign invalidate_prt_entry_slot    = inv_slot_q;
  assign tx_valid                     = tx_valid_q;
  assign tx_data                      = tx_data_q;
  assign tx_last                      = tx_last_q;
  assign frames_sent                  = sent_q;
  assign frames_dropped               = dropped_q;
  assign err_flag                     = err_q;

endmodule

// File: tb/tb_prt_tx_drain.sv
// Directed bench for prt_tx_drain: behavioural PRT responder plus MAC-side capture,
// with one task per scenario.
module tb_prt_tx_drain;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       cmd_valid, cmd_ready, cmd_drop;
  logic [3:0] cmd_slot;
  logic       EN_start, RDY_start, EN_read, RDY_read, EN_inv, RDY_inv;
  logic [3:0] start_slot, inv_slot;
  logic [8:0] read_entry;
  logic       tx_enable, tx_valid, tx_last, err_flag, busy;
  logic [7:0] tx_data;
  logic [15:0] frames_sent, frames_dropped;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       last;
    logic [7:0] data;
    int         cyc;
  } tx_beat_t;

  tx_beat_t   tx_log[$];
  logic [3:0] inv_log[$];
  int         cyc = 0;
  int         en_overlap = 0;
  int         slot_len [16];
  logic [7:0] slot_base [16];
  bit         slot_valid [16];
  int         rd_idx = 0;
  logic [3:0] rd_slot = '0;

  prt_tx_drain dut (
    .CLK                          (CLK),
    .RST_N                        (RST_N),
    .cmd_valid                    (cmd_valid),
    .cmd_ready                    (cmd_ready),
    .cmd_slot                     (cmd_slot),
    .cmd_drop                     (cmd_drop),
    .EN_start_reading_prt_entry   (EN_start),
    .RDY_start_reading_prt_entry  (RDY_start),
    .start_reading_prt_entry_slot (start_slot),
    .EN_read_prt_entry            (EN_read),
    .RDY_read_prt_entry           (RDY_read),
    .read_prt_entry               (read_entry),
    .EN_invalidate_prt_entry      (EN_inv),
    .RDY_invalidate_prt_entry     (RDY_inv),
    .invalidate_prt_entry_slot    (inv_slot),
    .tx_enable                    (tx_enable),
    .tx_valid                     (tx_valid),
    .tx_data                      (tx_data),
    .tx_last                      (tx_last),
    .frames_sent                  (frames_sent),
    .frames_dropped               (frames_dropped),
    .err_flag                     (err_flag),
    .busy                         (busy)
  );

  always #5 CLK = ~CLK;

  // PRT responder and MAC capture, both acting on the falling edge.
  initial begin
    forever begin
      @(negedge CLK);
      cyc++;
      if (int'(EN_start) + int'(EN_read) + int'(EN_inv) > 1) en_overlap++;
      if (tx_valid) tx_log.push_back('{last: tx_last, data: tx_data, cyc: cyc});
      RDY_start = 1'b0;
      RDY_inv   = 1'b0;
      if (EN_start && slot_valid[start_slot]) begin
        RDY_start = 1'b1;
        rd_slot   = start_slot;
        rd_idx    = 0;
      end
      if (EN_inv) begin
        RDY_inv = 1'b1;
        inv_log.push_back(inv_slot);
      end
      if (EN_read) begin
        RDY_read = 1'b1;
        if (rd_idx < slot_len[rd_slot]) read_entry = {1'b0, slot_base[rd_slot] + 8'(rd_idx)};
        else read_entry = {1'b1, 8'h00};
        rd_idx++;
      end else begin
        RDY_read   = 1'b0;
        read_entry = '0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic push_cmd(input logic drop, input logic [3:0] slot, output logic acc);
    cmd_valid = 1'b1;
    cmd_drop  = drop;
    cmd_slot  = slot;
    acc       = cmd_ready;
    @(negedge CLK);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    while (busy && n < bound) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: busy=%b after %0d cycles, required 0", name, busy, bound);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    checks++;
    if ({cmd_ready, busy, tx_valid, tx_last, err_flag} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags: {rdy,busy,valid,last,err}=%b required 10000",
               {cmd_ready, busy, tx_valid, tx_last, err_flag});
    end
    checks++;
    if ({EN_start, EN_read, EN_inv} !== 3'b000) begin
      errors++;
      $display("FAIL reset_en: EN=%b required 000", {EN_start, EN_read, EN_inv});
    end
    checks++;
    if (frames_sent !== 16'd0 || frames_dropped !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters: sent=%0d dropped=%0d required 0/0", frames_sent, frames_dropped);
    end
  endtask

  task automatic test_transmit();
    logic acc;
    tx_log.delete();
    inv_log.delete();
    push_cmd(1'b0, 4'd3, acc);
    checks++;
    if (acc !== 1'b1) begin errors++; $display("FAIL tx_push: accepted=%b required 1", acc); end
    wait_idle("tx_idle", 4000);
    checks++;
    if (tx_log.size() != 5) begin
      errors++;
      $display("FAIL tx_len: beats=%0d required 5", tx_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (tx_log[i].data !== 8'hA0 + 8'(i) || tx_log[i].last !== 1'(i == 4)) begin
          errors++;
          $display("FAIL tx_beat%0d: data=%h last=%b required %h/%b",
                   i, tx_log[i].data, tx_log[i].last, 8'hA0 + 8'(i), 1'(i == 4));
        end
      end
      checks++;
      if (tx_log[4].cyc - tx_log[0].cyc != 4) begin
        errors++;
        $display("FAIL tx_contiguous: span=%0d required 4", tx_log[4].cyc - tx_log[0].cyc);
      end
    end
    checks++;
    if (inv_log.size() != 1 || inv_log[0] !== 4'd3) begin
      errors++;
      $display("FAIL tx_invalidate: count=%0d slot=%0d required 1/3", inv_log.size(), inv_log[0]);
    end
    checks++;
    if (frames_sent !== 16'd1 || frames_dropped !== 16'd0 || err_flag !== 1'b0) begin
      errors++;
      $display("FAIL tx_stats: sent=%0d dropped=%0d err=%b required 1/0/0",
               frames_sent, frames_dropped, err_flag);
    end
  endtask

  task automatic test_drop();
    logic acc;
    int   n = 0;
    int   hold = 0;
    tx_log.delete();
    push_cmd(1'b1, 4'd2, acc);
    while (!EN_inv && n < 100) begin @(negedge CLK); n++; end
    checks++;
    if (EN_inv !== 1'b1 || inv_slot !== 4'd2) begin
      errors++;
      $display("FAIL drop_inv_req: EN_inv=%b slot=%0d required 1/2", EN_inv, inv_slot);
    end
    @(negedge CLK);
    while (inv_slot === 4'd2 && EN_inv === 1'b0 && hold < 3000) begin
      hold++;
      @(negedge CLK);
    end
    checks++;
    if (hold != 1519) begin
      errors++;
      $display("FAIL drop_hold: slot held %0d cycles, required 1519", hold);
    end
    checks++;
    if (frames_dropped !== 16'd1 || frames_sent !== 16'd1 || tx_log.size() != 0) begin
      errors++;
      $display("FAIL drop_stats: dropped=%0d sent=%0d beats=%0d required 1/1/0",
               frames_dropped, frames_sent, tx_log.size());
    end
    wait_idle("drop_idle", 100);
  endtask

  task automatic test_empty();
    logic acc;
    tx_log.delete();
    inv_log.delete();
    push_cmd(1'b0, 4'd0, acc);
    wait_idle("empty_idle", 4000);
    checks++;
    if (tx_log.size() != 0 || frames_dropped !== 16'd2 || frames_sent !== 16'd1) begin
      errors++;
      $display("FAIL empty_stats: beats=%0d dropped=%0d sent=%0d required 0/2/1",
               tx_log.size(), frames_dropped, frames_sent);
    end
    checks++;
    if (inv_log.size() != 1 || inv_log[0] !== 4'd0 || err_flag !== 1'b0) begin
      errors++;
      $display("FAIL empty_invalidate: count=%0d slot=%0d err=%b required 1/0/0",
               inv_log.size(), inv_log[0], err_flag);
    end
  endtask

  task automatic test_overlong();
    logic acc;
    int   lasts = 0;
    tx_log.delete();
    checks++;
    if (err_flag !== 1'b0) begin errors++; $display("FAIL long_err_pre: err=%b required 0", err_flag); end
    push_cmd(1'b0, 4'd9, acc);
    wait_idle("long_idle", 5000);
    checks++;
    if (tx_log.size() != 1518) begin
      errors++;
      $display("FAIL long_len: beats=%0d required 1518", tx_log.size());
    end else begin
      foreach (tx_log[i]) if (tx_log[i].last) lasts++;
      checks++;
      if (tx_log[0].data !== 8'h10 || tx_log[1517].data !== 8'hFD || !tx_log[1517].last || lasts != 1) begin
        errors++;
        $display("FAIL long_ends: first=%h last=%h lastflag=%b lasts=%0d required 10/fd/1/1",
                 tx_log[0].data, tx_log[1517].data, tx_log[1517].last, lasts);
      end
      checks++;
      if (tx_log[1517].cyc - tx_log[0].cyc != 1517) begin
        errors++;
        $display("FAIL long_contiguous: span=%0d required 1517", tx_log[1517].cyc - tx_log[0].cyc);
      end
    end
    checks++;
    if (err_flag !== 1'b1 || frames_sent !== 16'd2 || frames_dropped !== 16'd2) begin
      errors++;
      $display("FAIL long_stats: err=%b sent=%0d dropped=%0d required 1/2/2",
               err_flag, frames_sent, frames_dropped);
    end
  endtask

  task automatic test_reset_mid_stream();
    logic acc;
    int   n = 0;
    push_cmd(1'b0, 4'd9, acc);
    while (!tx_valid && n < 200) begin @(negedge CLK); n++; end
    checks++;
    if (tx_valid !== 1'b1) begin errors++; $display("FAIL mid_stream_start: tx_valid=%b required 1", tx_valid); end
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if ({tx_valid, tx_last, tx_data, EN_start, EN_read, EN_inv} !== 13'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: {valid,last,data,EN}=%h required 0",
               {tx_valid, tx_last, tx_data, EN_start, EN_read, EN_inv});
    end
    checks++;
    if ({start_slot, inv_slot} !== 8'd0 || {busy, cmd_ready, err_flag} !== 3'b010) begin
      errors++;
      $display("FAIL mid_reset_state: slots=%h {busy,rdy,err}=%b required 0/010",
               {start_slot, inv_slot}, {busy, cmd_ready, err_flag});
    end
    checks++;
    if (frames_sent !== 16'd0 || frames_dropped !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset_counters: sent=%0d dropped=%0d required 0/0", frames_sent, frames_dropped);
    end
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    tx_log.delete();
    repeat (20) @(negedge CLK);
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1 || tx_log.size() != 0 || frames_sent !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset_after: busy=%b rdy=%b beats=%0d sent=%0d required 0/1/0/0",
               busy, cmd_ready, tx_log.size(), frames_sent);
    end
  endtask

  task automatic test_timeout();
    logic acc;
    int   n = 0;
    int   en_cycles = 0;
    tx_log.delete();
    push_cmd(1'b0, 4'd7, acc);
    while (!EN_start && n < 50) begin @(negedge CLK); n++; end
    while (EN_start && en_cycles < 100) begin en_cycles++; @(negedge CLK); end
    checks++;
    if (en_cycles != 16) begin
      errors++;
      $display("FAIL timeout_len: EN_start high %0d cycles, required 16", en_cycles);
    end
    checks++;
    if (EN_inv !== 1'b1 || inv_slot !== 4'd7 || err_flag !== 1'b1) begin
      errors++;
      $display("FAIL timeout_inv: EN_inv=%b slot=%0d err=%b required 1/7/1", EN_inv, inv_slot, err_flag);
    end
    wait_idle("timeout_idle", 4000);
    checks++;
    if (frames_dropped !== 16'd1 || frames_sent !== 16'd0 || tx_log.size() != 0) begin
      errors++;
      $display("FAIL timeout_stats: dropped=%0d sent=%0d beats=%0d required 1/0/0",
               frames_dropped, frames_sent, tx_log.size());
    end
  endtask

  task automatic test_back_to_back();
    logic       acc;
    logic [7:0] exp_data [8] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h40, 8'h41, 8'h42};
    int         gap;
    tx_log.delete();
    inv_log.delete();
    push_cmd(1'b0, 4'd3, acc);
    push_cmd(1'b0, 4'd4, acc);
    wait_idle("b2b_idle", 6000);
    checks++;
    if (tx_log.size() != 8) begin
      errors++;
      $display("FAIL b2b_len: beats=%0d required 8", tx_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (tx_log[i].data !== exp_data[i] || tx_log[i].last !== 1'(i == 4 || i == 7)) begin
          errors++;
          $display("FAIL b2b_beat%0d: data=%h last=%b required %h/%b",
                   i, tx_log[i].data, tx_log[i].last, exp_data[i], 1'(i == 4 || i == 7));
        end
      end
      gap = tx_log[5].cyc - tx_log[4].cyc - 1;
      checks++;
      if (gap < 12) begin errors++; $display("FAIL b2b_gap: idle=%0d required >=12", gap); end
    end
    checks++;
    if (frames_sent !== 16'd2 || inv_log.size() != 2 || inv_log[0] !== 4'd3 || inv_log[1] !== 4'd4) begin
      errors++;
      $display("FAIL b2b_stats: sent=%0d invs=%0d required 2/2 (slots 3,4)", frames_sent, inv_log.size());
    end
  endtask

  task automatic test_tx_enable();
    logic acc;
    int   starts = 0;
    tx_log.delete();
    tx_enable = 1'b0;
    push_cmd(1'b0, 4'd3, acc);
    repeat (30) begin
      if (EN_start) starts++;
      @(negedge CLK);
    end
    checks++;
    if (starts != 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL txen_gate: starts=%0d busy=%b required 0/1", starts, busy);
    end
    tx_enable = 1'b1;
    wait_idle("txen_idle", 4000);
    checks++;
    if (tx_log.size() != 5 || frames_sent !== 16'd3) begin
      errors++;
      $display("FAIL txen_release: beats=%0d sent=%0d required 5/3", tx_log.size(), frames_sent);
    end
  endtask

  task automatic test_queue_full();
    logic       acc;
    logic [3:0] slots [4] = '{4'd5, 4'd6, 4'd8, 4'd1};
    int         n = 0;
    inv_log.delete();
    for (int i = 0; i < 4; i++) begin
      push_cmd(1'b1, slots[i], acc);
      checks++;
      if (acc !== 1'b1) begin errors++; $display("FAIL qfull_push%0d: accepted=%b required 1", i, acc); end
    end
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL qfull_ready: cmd_ready=%b required 0", cmd_ready); end
    push_cmd(1'b1, 4'd9, acc);
    checks++;
    if (acc !== 1'b0) begin errors++; $display("FAIL qfull_fifth: accepted=%b required 0", acc); end
    while (!cmd_ready && n < 3000) begin @(negedge CLK); n++; end
    checks++;
    if (cmd_ready !== 1'b1 || frames_dropped !== 16'd2) begin
      errors++;
      $display("FAIL qfull_retire: cmd_ready=%b dropped=%0d required 1/2", cmd_ready, frames_dropped);
    end
    wait_idle("qfull_idle", 8000);
    checks++;
    if (frames_dropped !== 16'd5 || inv_log.size() != 4) begin
      errors++;
      $display("FAIL qfull_stats: dropped=%0d invs=%0d required 5/4", frames_dropped, inv_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (inv_log[i] !== slots[i]) begin
          errors++;
          $display("FAIL qfull_order%0d: slot=%0d required %0d", i, inv_log[i], slots[i]);
        end
      end
    end
  endtask

  task automatic test_en_exclusive();
    checks++;
    if (en_overlap != 0) begin
      errors++;
      $display("FAIL en_exclusive: overlapping cycles=%0d required 0", en_overlap);
    end
  endtask

  initial begin
    RST_N      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_drop   = 1'b0;
    cmd_slot   = '0;
    RDY_start  = 1'b0;
    RDY_read   = 1'b0;
    RDY_inv    = 1'b0;
    read_entry = '0;
    tx_enable  = 1'b1;
    for (int s = 0; s < 16; s++) begin
      slot_len[s]   = 0;
      slot_base[s]  = 8'h00;
      slot_valid[s] = (s < 10) && (s != 7);
    end
    slot_len[3] = 5;    slot_base[3] = 8'hA0;
    slot_len[4] = 3;    slot_base[4] = 8'h40;
    slot_len[9] = 2000; slot_base[9] = 8'h10;

    test_reset();
    test_transmit();
    test_drop();
    test_empty();
    test_overlong();
    test_reset_mid_stream();
    test_timeout();
    test_back_to_back();
    test_tx_enable();
    test_queue_full();
    test_en_exclusive();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
